mdu_seq: RTL and testbench



---
 rtl/mdu_seq_pkg.sv | 32 +++
 rtl/mdu_seq_alu.sv | 32 +++
 rtl/mdu_seq.sv | 139 +++++++++++++
 tb/tb_mdu_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and its ALU.
//   - XLEN        : operand width
//   - alu_ctl_e   : ALU control codes (ADD/SUB used by the sequencer)
//   - mdu_state_e : sequencer states
//   - mdu_op_e    : MULTU/DIVU operation select
package mdu_seq_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic {
    OP_MULTU = 1'b0,
    OP_DIVU  = 1'b1
  } mdu_op_e;

endpackage

// File: rtl/mdu_seq_alu.sv
// 32-bit combinational ALU, shared design with the execute-stage ALU.
// Ports:
//   ctl      in  alu_ctl_e  operation select
//   data_1   in  XLEN       first operand
//   data_2   in  XLEN       second operand
//   result_c out XLEN       combinational result
module mdu_seq_alu
  import mdu_seq_pkg::*;
(
  input  alu_ctl_e          ctl,
  input  logic [XLEN-1:0]   data_1,
  input  logic [XLEN-1:0]   data_2,
  output logic [XLEN-1:0]   result_c
);

  // Operation decode
  always_comb begin
    result_c = '0;
    case (ctl)
      ALU_ADD:  result_c = data_1 + data_2;
      ALU_SUB:  result_c = data_1 - data_2;
      ALU_AND:  result_c = data_1 & data_2;
      ALU_OR:   result_c = data_1 | data_2;
      ALU_XOR:  result_c = data_1 ^ data_2;
      ALU_NOR:  result_c = ~(data_1 | data_2);
      ALU_SLT:  result_c = XLEN'($signed(data_1) < $signed(data_2));
      ALU_SLTU: result_c = XLEN'(data_1 < data_2);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer owning the HI/LO pair.
// One ALU add (multiply) or subtract (restoring divide) per cycle, ITER cycles.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, op         launch request (0=MULTU, 1=DIVU), taken when not busy
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we,     MTHI/MTLO writes, taken when not busy and no start
//   wdata
//   busy              high while iterating
//   done              one-cycle pulse when hi/lo hold a new result
//   hi, lo            product[63:32]/[31:0] or remainder/quotient
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo
);

  localparam int unsigned CNT_W = $clog2(ITER);

  mdu_state_e         state;
  mdu_op_e            op_q;
  logic [CNT_W-1:0]   cnt;
  logic [XLEN-1:0]    src_b_q;
  // acc_hi/acc_lo double as rem/quo during a divide
  logic [XLEN-1:0]    acc_hi;
  logic [XLEN-1:0]    acc_lo;

  alu_ctl_e           alu_ctl;
  logic [XLEN-1:0]    alu_d1;
  logic [XLEN-1:0]    alu_d2;
  logic [XLEN-1:0]    alu_res;

  logic [XLEN:0]      div_s;
  logic               div_ge;
  logic               mul_carry;
  logic [XLEN-1:0]    step_hi;
  logic [XLEN-1:0]    step_lo;

  mdu_seq_alu u_alu (
    .ctl      (alu_ctl),
    .data_1   (alu_d1),
    .data_2   (alu_d2),
    .result_c (alu_res)
  );

  // Operand selection and next working-register values for one iteration
  always_comb begin
    div_s     = {acc_hi, acc_lo[XLEN-1]};
    alu_ctl   = ALU_ADD;
    alu_d1    = acc_hi;
    alu_d2    = acc_lo[0] ? src_b_q : '0;
    mul_carry = 1'b0;
    div_ge    = 1'b0;
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (op_q == OP_DIVU) begin
      alu_ctl = ALU_SUB;
      alu_d1  = div_s[XLEN-1:0];
      alu_d2  = src_b_q;
      // bit XLEN of the shifted remainder means it already exceeds any divisor
      div_ge  = div_s[XLEN] | (div_s[XLEN-1:0] >= src_b_q);
      step_hi = div_ge ? alu_res : div_s[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      // add wrapped around iff the sum is below an operand
      mul_carry = alu_res < acc_hi;
      step_hi   = {mul_carry, alu_res[XLEN-1:1]};
      step_lo   = {alu_res[0], acc_lo[XLEN-1:1]};
    end
  end

  // Sequencer state, working registers and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      src_b_q <= '0;
      op_q    <= OP_MULTU;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            op_q    <= mdu_op_e'(op);
            src_b_q <= src_b;
            acc_hi  <= '0;
            acc_lo  <= src_a;
            cnt     <= '0;
          end else begin
            state <= ST_IDLE;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= step_hi;
            lo    <= step_lo;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random MULTU/DIVU
// against a plain-arithmetic reference model.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_seq #(.ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi, lo} as the architecture defines MULTU/DIVU
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] r;
    if (!o) r = 64'(a) * 64'(b);
    else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
    else r = {a % b, a / b};
    return r;
  endfunction

  task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Called just after the accepting edge; ends in the DONE cycle
  task automatic finish_op(input string tag, input logic [63:0] exp, input bit disturb);
    int   nbusy = 0;
    logic saw_done = 1'b0;
    logic hold_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (busy) nbusy++;
      if (done) saw_done = 1'b1;
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      if (disturb && i == 5) begin
        start = 1'b1; op = ~op; src_a = $urandom; src_b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      if (disturb && i == 7) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      tick;
    end
    check({tag, " busy_cycles"}, 64'(nbusy), 64'd32);
    check({tag, " hold_hilo"}, 64'(hold_ok), 64'd1);
    check({tag, " early_done"}, 64'(saw_done), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    start_op(o, a, b);
    finish_op(tag, ref_result(o, a, b), disturb);
    tick;
    check({tag, " done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic        ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          ndone;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) tick;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    tick;

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 1'b0);
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 1'b0);
    run_op("divmax_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("div5_0", 1'b1, 32'd5, 32'd0, 1'b0);
    run_op("mul_disturb", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op("div_disturb", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

    // Back-to-back: second start during the DONE cycle
    start_op(1'b0, 32'd123, 32'd456);
    finish_op("b2b_first", ref_result(1'b0, 32'd123, 32'd456), 1'b0);
    start_op(1'b1, 32'd1000, 32'd3);
    finish_op("b2b_second", ref_result(1'b1, 32'd1000, 32'd3), 1'b0);
    tick;

    // MTLO / MTHI while idle
    lo_we = 1'b1; wdata = 32'h1234_5678;
    tick;
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'h1234_5678);
    check("mtlo hi", 64'(hi), 64'(m_hi));
    m_lo = 32'h1234_5678;
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick;
    hi_we = 1'b0;
    check("mthi hi", 64'(hi), 64'hCAFE_F00D);
    check("mthi lo", 64'(lo), 64'(m_lo));
    m_hi = 32'hCAFE_F00D;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
    tick;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth hi", 64'(hi), 64'hA5A5_5A5A);
    check("mtboth lo", 64'(lo), 64'hA5A5_5A5A);
    m_hi = 32'hA5A5_5A5A;
    m_lo = 32'hA5A5_5A5A;

    // MTLO in the same cycle as start is dropped
    op = 1'b0; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick;
    start = 1'b0; lo_we = 1'b0;
    check("mtlo_start lo", 64'(lo), 64'(m_lo));
    finish_op("mtlo_start", ref_result(1'b0, 32'd7, 32'd6), 1'b0);
    tick;

    // Reset at iteration 10 aborts
    start_op(1'b0, 32'h8765_4321, 32'h1357_9BDF);
    repeat (10) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      tick;
    end
    check("abort no_done", 64'(ndone), 64'd0);

    // Random operations
    for (int n = 0; n < 20; n++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d_%s", n, ro ? "div" : "mul"), ro, ra, rb, n % 5 == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
